// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit for the execute stage: fixed-latency multiply,
// one-bit-per-cycle restoring divide, MTHI/MTLO writes and flush cancellation.
module mul_div_unit #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 3
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic is_signed);
      return (is_signed && v[WIDTH-1]) ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v,
                                                  input logic neg);
      return neg ? -v : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y,
                                                   input logic is_signed);
      logic [2*WIDTH-1:0] ex;
      logic [2*WIDTH-1:0] ey;
      ex = {{WIDTH{is_signed & x[WIDTH-1]}}, x};
      ey = {{WIDTH{is_signed & y[WIDTH-1]}}, y};
      return ex * ey;
   endfunction

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH-1:0]   opa_q, opa_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic               sgn_q, sgn_d;
   logic               qneg_q, qneg_d;
   logic               rneg_q, rneg_d;
   logic               dz_q, dz_d;

   logic               accept;
   logic               div_signed;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     diff;

   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign hi         = hi_q;
   assign lo         = lo_q;
   assign accept     = start && !busy && !flush;
   assign div_signed = (op == OP_DIV);
   assign prod       = mul_full(opa_q, opb_q, sgn_q);
   // opa_q doubles as the dividend shift register; quotient bits fill in from the bottom
   assign shifted    = {rem_q, opa_q[WIDTH-1]};
   assign diff       = shifted - {1'b0, opb_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      rem_d   = rem_q;
      sgn_d   = sgn_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     opa_d   = a;
                     opb_d   = b;
                     sgn_d   = (op == OP_MULT);
                     cnt_d   = '0;
                     state_d = S_MUL;
                  end
                  OP_DIV, OP_DIVU: begin
                     opa_d   = magnitude(a, div_signed);
                     opb_d   = magnitude(b, div_signed);
                     rem_d   = '0;
                     qneg_d  = div_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                     rneg_d  = div_signed & a[WIDTH-1];
                     dz_d    = (b == '0);
                     cnt_d   = '0;
                     state_d = (b == '0) ? S_FIX : S_DIV;
                  end
                  OP_MTHI: begin
                     hi_d   = a;
                     done_d = 1'b1;
                  end
                  OP_MTLO: begin
                     lo_d   = a;
                     done_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (cnt_q == MUL_LAST) begin
               hi_d    = prod[2*WIDTH-1:WIDTH];
               lo_d    = prod[WIDTH-1:0];
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DIV: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               if (!diff[WIDTH]) begin
                  rem_d = diff[WIDTH-1:0];
                  opa_d = {opa_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_d = shifted[WIDTH-1:0];
                  opa_d = {opa_q[WIDTH-2:0], 1'b0};
               end
               if (cnt_q == DIV_LAST) begin
                  state_d = S_FIX;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_FIX: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               if (!dz_q) begin
                  lo_d = negate_if(opa_q, qneg_q);
                  hi_d = negate_if(rem_q, rneg_q);
               end
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // operand and divider datapath registers carry no reset; control gates their use
   always_ff @(posedge clk) begin
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      rem_q  <= rem_d;
      sgn_q  <= sgn_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
   end

endmodule
